decoder_sequencer: RTL
======================

Name: decoder_sequencer

Overview:
- Cycle-accurate sequencer that drives the SM83 instruction decoder input bus a[25:0] from real fetch/interrupt state.
- Holds IR, CB-prefix mode, interrupt-dispatch flag, the 3-bit M-cycle step counter and the T-phase counter.
- Replaces the free-running counter stub used for decoder cross-check dumps.
- Sits between the fetch/bus unit and the Decoder1/2/3 chain.

Parameters:
- CB_PREFIX, 8'hCB: opcode that arms CB mode for the next instruction.
- IRQ_OPCODE, 8'h00: value loaded into IR on interrupt dispatch.

Ports:
- CLK  in  1  core clock; one T-cycle per edge.
- RESET  in  1  synchronous, active-high reset.
- stall  in  1  wait state; freezes phase, state, IR and flags.
- fetch_data  in  8  opcode byte on the data bus; sampled at M-cycle boundary.
- instr_done  in  1  decoder flag: current M-cycle is the last of the instruction.
- irq_req  in  1  pending, enabled interrupt; sampled at M-cycle boundary.
- ir  out  8  current instruction register.
- state  out  3  M-cycle step within the instruction.
- cb_mode  out  1  current instruction is CB-prefixed.
- intr_dispatch  out  1  interrupt dispatch sequence is active.
- phase  out  2  T-phase within the M-cycle.
- clk5  out  1  writeback strobe; equals phase[0].
- seq_out_2  out  1  equals ~phase[1].
- a  out  26  decoder bus, combinational from registers:
  - a[1]=intr_dispatch, a[0]=~a[1]
  - a[3]=cb_mode, a[2]=~a[3]
  - a[5],a[7],...,a[19] = ir[7],ir[6],...,ir[0]; a[2k]=~a[2k+1] for k=2..9
  - a[21]=state[2], a[20]=~a[21]
  - a[23]=state[1], a[22]=~a[23]
  - a[25]=state[0], a[24]=~a[25]
- seq_err  out  1  sticky flag: step overrun.

Behaviour:
- Reset: ir=8'h00, state=0, cb_mode=0, intr_dispatch=0, phase=0, seq_err=0, FSM=EXEC. Core starts executing a NOP at step 0; that NOP's M-cycle fetches the first opcode.
- RESET has priority over all other inputs, including stall and a mid-instruction state.
- Phase counter: when !stall, increments 0→1→2→3→0 each clock. One M-cycle = 4 clocks.
- Boundary event B = (phase==3 && !stall). All registers other than phase change only on B.
- stall=1: every register holds, including phase; the a bus stays constant.
- FSM states: EXEC, HALT (HALT exists only with the optional feature).
- EXEC on B, priority order:
  1. instr_done && irq_req: intr_dispatch<=1, cb_mode<=0, ir<=IRQ_OPCODE, state<=0. fetch_data is ignored.
  2. instr_done: ir<=fetch_data, state<=0, intr_dispatch<=0, cb_mode<=(ir==CB_PREFIX && !cb_mode && !intr_dispatch). A CB opcode executed in CB mode therefore does not re-arm. IRQ is never taken between a prefix and its CB instruction: when the prefix is completing, irq_req is ignored for that boundary.
  3. !instr_done && state<7: state<=state+1.
  4. !instr_done && state==7: state holds at 7, seq_err<=1 (sticky until RESET).
- Outputs are registered, so ir/state/flags change on the clock edge ending phase 3. The a bus follows on the same edge with zero extra latency.
- clk5 and seq_out_2 are combinational from phase.

Optional Feature:
- Macro: DECSEQ_HALT_EN.
- With the macro:
  - Adds input halt_req (1) and output halted (1).
  - On B in EXEC with instr_done && halt_req && !irq_req: FSM<=HALT, halted<=1. ir, state and flags are frozen; phase keeps running.
  - In HALT on B with irq_req: FSM<=EXEC, halted<=0, then the dispatch load of rule 1 is applied on that same edge.
  - halt_req while in CB mode or during dispatch is ignored.
  - halted resets to 0.
- Without the macro: no halt_req/halted ports, no HALT state; behaviour is exactly as above.

Test Plan:
- Reset, then 4 clocks with instr_done=1, fetch_data=8'h3E → at the edge ending phase 3: ir=8'h3E, state=0; a[5..19] alternates per 0x3E, a[1]=0, a[3]=0.
- ir=8'h3E, instr_done=0 for 2 M-cycles then 1 with fetch_data=8'h00 → state 0→1→2, then ir=8'h00, state=0; a[21..25] odd bits track state.
- Boundary loads CB_PREFIX (8'hCB), next boundary fetch_data=8'h37 with irq_req=1 → ir=8'h37, cb_mode=1, intr_dispatch=0 (IRQ deferred). Next boundary with instr_done=1, irq_req=1 → intr_dispatch=1, ir=8'h00, cb_mode=0, a[1]=1, a[0]=0.
- instr_done=0 held for 8 M-cycles → state saturates at 7 and seq_err=1. Assert RESET mid-phase 2 → next clock all outputs at reset values, seq_err=0.
- stall=1 for 5 clocks at phase 2 → phase, a, clk5 and seq_out_2 constant. After release, the boundary occurs 2 clocks later (phase 2→3→0).
- DECSEQ_HALT_EN: instr_done=1, halt_req=1 → halted=1, ir frozen through 3 M-cycles. Then irq_req=1 → halted=0, intr_dispatch=1, ir=IRQ_OPCODE on that boundary.

Source files
------------

// File: rtl/decoder_sequencer.sv
// Sequencer that drives the SM83 decoder input bus a[25:0] from IR, CB/IRQ flags and M-cycle step.
// Defining DECSEQ_HALT_EN adds the HALT state with the halt_req input and the halted output.
module decoder_sequencer #(
    parameter logic [7:0] CB_PREFIX  = 8'hCB,
    parameter logic [7:0] IRQ_OPCODE = 8'h00
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        stall,
    input  logic [7:0]  fetch_data,
    input  logic        instr_done,
    input  logic        irq_req,
`ifdef DECSEQ_HALT_EN
    input  logic        halt_req,
    output logic        halted,
`endif
    output logic [7:0]  ir,
    output logic [2:0]  state,
    output logic        cb_mode,
    output logic        intr_dispatch,
    output logic [1:0]  phase,
    output logic        clk5,
    output logic        seq_out_2,
    output logic [25:0] a,
    output logic        seq_err
);

    localparam int unsigned IR_W   = 8;
    localparam int unsigned ST_W   = 3;
    localparam int unsigned PH_W   = 2;
    localparam logic [ST_W-1:0] ST_MAX    = ST_W'(7);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(3);

`ifdef DECSEQ_HALT_EN
    typedef enum logic [0:0] {EXEC = 1'b0, HALT = 1'b1} fsm_t;
`else
    typedef enum logic [0:0] {EXEC = 1'b0} fsm_t;
`endif

    fsm_t            fsm_q;
    logic [IR_W-1:0] ir_q;
    logic [ST_W-1:0] state_q;
    logic            cb_mode_q;
    logic            intr_q;
    logic [PH_W-1:0] phase_q;
    logic            seq_err_q;

    logic            boundary_c;
    logic            prefix_done_c;
    logic            take_irq_c;

    assign boundary_c    = (phase_q == PH_LAST) && !stall;
    // A completing CB prefix blocks IRQ so the prefixed opcode is never separated from it.
    assign prefix_done_c = (ir_q == CB_PREFIX) && !cb_mode_q && !intr_q;
    assign take_irq_c    = instr_done && irq_req && !prefix_done_c;

`ifdef DECSEQ_HALT_EN
    logic halted_q;
    logic halt_go_c;

    assign halt_go_c = instr_done && halt_req && !irq_req && !cb_mode_q && !intr_q;
    assign halted    = halted_q;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fsm_q     <= EXEC;
            ir_q      <= '0;
            state_q   <= '0;
            cb_mode_q <= 1'b0;
            intr_q    <= 1'b0;
            phase_q   <= '0;
            seq_err_q <= 1'b0;
`ifdef DECSEQ_HALT_EN
            halted_q  <= 1'b0;
`endif
        end else if (!stall) begin
            phase_q <= phase_q + PH_W'(1);
            if (boundary_c) begin
                if (fsm_q == EXEC) begin
                    if (take_irq_c) begin
                        intr_q    <= 1'b1;
                        cb_mode_q <= 1'b0;
                        ir_q      <= IRQ_OPCODE;
                        state_q   <= '0;
`ifdef DECSEQ_HALT_EN
                    end else if (halt_go_c) begin
                        fsm_q    <= HALT;
                        halted_q <= 1'b1;
`endif
                    end else if (instr_done) begin
                        ir_q      <= fetch_data;
                        state_q   <= '0;
                        intr_q    <= 1'b0;
                        cb_mode_q <= prefix_done_c;
                    end else if (state_q != ST_MAX) begin
                        state_q <= state_q + ST_W'(1);
                    end else begin
                        seq_err_q <= 1'b1;
                    end
                end
`ifdef DECSEQ_HALT_EN
                else if (irq_req) begin
                    // Wake and dispatch on the same boundary.
                    fsm_q     <= EXEC;
                    halted_q  <= 1'b0;
                    intr_q    <= 1'b1;
                    cb_mode_q <= 1'b0;
                    ir_q      <= IRQ_OPCODE;
                    state_q   <= '0;
                end
`endif
            end
        end
    end

    assign ir            = ir_q;
    assign state         = state_q;
    assign cb_mode       = cb_mode_q;
    assign intr_dispatch = intr_q;
    assign phase         = phase_q;
    assign seq_err       = seq_err_q;
    assign clk5          = phase_q[0];
    assign seq_out_2     = ~phase_q[1];

    // Decoder bus: each odd bit carries a field bit, the even bit below it its complement.
    assign a[1]  = intr_q;
    assign a[0]  = ~intr_q;
    assign a[3]  = cb_mode_q;
    assign a[2]  = ~cb_mode_q;
    assign a[21] = state_q[2];
    assign a[20] = ~state_q[2];
    assign a[23] = state_q[1];
    assign a[22] = ~state_q[1];
    assign a[25] = state_q[0];
    assign a[24] = ~state_q[0];

    for (genvar i = 0; i < 8; i++) begin : g_ir_bus
        assign a[19-2*i] = ir_q[i];
        assign a[18-2*i] = ~ir_q[i];
    end

endmodule
